// File: rtl/vga_fb_pkg.sv
// Shared definitions for the framebuffer write path.
//   fb_state_e     : write-engine FSM states
//   MODE_UNPACK/
//   MODE_FILL      : values of the writer's mode input
//   pix_per_word() : pixels carried by one input word
package vga_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FIN   = 2'd2
  } fb_state_e;

  localparam logic MODE_UNPACK = 1'b0;
  localparam logic MODE_FILL   = 1'b1;

  function automatic int unsigned pix_per_word(input int unsigned data_w,
                                               input int unsigned pix_w);
    return data_w / pix_w;
  endfunction

endpackage

// File: rtl/fb_pixel_unpacker.sv
// Load/rotate register presenting one pixel per advance, MSB first.
//   clk_i, rst_i : clock, synchronous active-high reset (clears to 0)
//   load_i       : capture word_i (has priority over advance_i)
//   advance_i    : move the next pixel to the output
//   word_i       : DATA_W-bit word to split
//   pixel_o      : current pixel, taken straight from the register top bits
module fb_pixel_unpacker #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PIX_W  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [PIX_W-1:0]  pixel_o
);

  logic [DATA_W-1:0] sr_q, sr_d;

  // Rotating rather than shifting lets a FILL job run for any length: the
  // writer loads the colour replicated across the word, so every position
  // holds the same pixel.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = word_i;
    end else if (advance_i) begin
      sr_d = (sr_q << PIX_W) | (sr_q >> (DATA_W - PIX_W));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign pixel_o = sr_q[DATA_W-1 -: PIX_W];

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer write engine: streams one pixel per clock into the frame RAM
// write port from a base address upward, either unpacking one input word
// (MSB first) or filling `count` addresses with one colour.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   start          : job request, sampled only while idle
//   mode           : 0 = UNPACK, 1 = FILL
//   dados_in       : UNPACK word; low PIX_W bits are the FILL colour
//   endereco_base  : first write address
//   count          : FILL pixel count (0 = no writes)
//   data/wraddress/wren : RAM write port, all registered
//   busy           : job in progress (write cycles)
//   done           : one-cycle end-of-job pulse
//   overflow       : WRAP=0 only, job truncated at top address; sticky until next start
module fb_pixel_writer
  import vga_fb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PIX_W  = 1,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 13,
  parameter int unsigned WRAP   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] dados_in,
  input  logic [ADDR_W-1:0] endereco_base,
  input  logic [CNT_W-1:0]  count,
  output logic [PIX_W-1:0]  data,
  output logic [ADDR_W-1:0] wraddress,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned PPW = pix_per_word(DATA_W, PIX_W);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              ovf_q, ovf_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              load, advance;
  logic [CNT_W-1:0]  job_len;
  logic [DATA_W-1:0] load_word;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    ovf_d     = ovf_q;
    load      = 1'b0;
    advance   = 1'b0;
    job_len   = (mode == MODE_FILL) ? count : CNT_W'(PPW);
    load_word = (mode == MODE_FILL) ? {PPW{dados_in[PIX_W-1:0]}} : dados_in;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          addr_d  = endereco_base;
          rem_d   = job_len;
          ovf_d   = 1'b0;
          state_d = (job_len == '0) ? ST_FIN : ST_WRITE;
        end
      end
      ST_WRITE: begin
        // rem_q counts the pixel currently on the port; last-pixel wins over
        // the top-address check so an exact fit is not flagged.
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_FIN;
        end else if ((WRAP == 0) && (addr_q == '1)) begin
          ovf_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          rem_d   = rem_q - CNT_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          advance = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave flops directly.
    wren_d = (state_d == ST_WRITE);
    busy_d = (state_d == ST_WRITE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  fb_pixel_unpacker #(
    .DATA_W(DATA_W),
    .PIX_W (PIX_W)
  ) u_unpacker (
    .clk_i    (clock),
    .rst_i    (reset),
    .load_i   (load),
    .advance_i(advance),
    .word_i   (load_word),
    .pixel_o  (data)
  );

  assign wraddress = addr_q;
  assign wren      = wren_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Three writer instances (1bpp wrap, 4bpp wrap, 1bpp no-wrap) share one
// stimulus stream; each has its own expected-event queue and monitor.
module tb_fb_pixel_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode  = 1'b0;
  logic [31:0] dados_in = '0;
  logic [11:0] endereco_base = '0;
  logic [12:0] count = '0;

  logic [0:0]  data_a, data_c;
  logic [3:0]  data_b;
  logic [11:0] addr_a, addr_b, addr_c;
  logic        wren_a, wren_b, wren_c, busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;

  always #5 clock = ~clock;

  fb_pixel_writer #(.DATA_W(32), .PIX_W(1), .ADDR_W(12), .CNT_W(13), .WRAP(1)) dut_a (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .dados_in(dados_in),
    .endereco_base(endereco_base), .count(count), .data(data_a), .wraddress(addr_a),
    .wren(wren_a), .busy(busy_a), .done(done_a), .overflow(ovf_a));

  fb_pixel_writer #(.DATA_W(32), .PIX_W(4), .ADDR_W(12), .CNT_W(13), .WRAP(1)) dut_b (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .dados_in(dados_in),
    .endereco_base(endereco_base), .count(count), .data(data_b), .wraddress(addr_b),
    .wren(wren_b), .busy(busy_b), .done(done_b), .overflow(ovf_b));

  fb_pixel_writer #(.DATA_W(32), .PIX_W(1), .ADDR_W(12), .CNT_W(13), .WRAP(0)) dut_c (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .dados_in(dados_in),
    .endereco_base(endereco_base), .count(count), .data(data_c), .wraddress(addr_c),
    .wren(wren_c), .busy(busy_c), .done(done_c), .overflow(ovf_c));

  logic [3:0]  m_data [3];
  logic [11:0] m_addr [3];
  logic        m_wren [3], m_busy [3], m_done [3], m_ovf [3];

  assign m_data[0] = {3'b000, data_a};
  assign m_data[1] = data_b;
  assign m_data[2] = {3'b000, data_c};
  assign m_addr[0] = addr_a;  assign m_addr[1] = addr_b;  assign m_addr[2] = addr_c;
  assign m_wren[0] = wren_a;  assign m_wren[1] = wren_b;  assign m_wren[2] = wren_c;
  assign m_busy[0] = busy_a;  assign m_busy[1] = busy_b;  assign m_busy[2] = busy_c;
  assign m_done[0] = done_a;  assign m_done[1] = done_b;  assign m_done[2] = done_c;
  assign m_ovf[0]  = ovf_a;   assign m_ovf[1]  = ovf_b;   assign m_ovf[2]  = ovf_c;

  localparam int unsigned PIXW [3] = '{1, 4, 1};
  localparam bit          WRAPP[3] = '{1'b1, 1'b1, 1'b0};

  typedef struct {
    bit          is_done;
    int unsigned cyc;
    logic [11:0] addr;
    logic [3:0]  data;
    bit          ovf;
  } exp_t;

  exp_t        expq [3][$];
  int unsigned cyc = 0;
  int unsigned n_chk = 0, n_pass = 0;
  int unsigned free_at [3] = '{0, 0, 0};
  int unsigned busy_lo [3] = '{0, 0, 0};
  int unsigned busy_n  [3] = '{0, 0, 0};
  int unsigned rst_cyc = 0;
  bit          rst_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: a job is a list of (cycle, address, pixel) writes plus a done
  // event, derived from base, length and the wrap rule with plain arithmetic.
  task automatic accept(input int d);
    int unsigned n, wr, mask, b;
    bit ov;
    exp_t e;
    b    = 32'(endereco_base);
    mask = (1 << PIXW[d]) - 1;
    n    = mode ? 32'(count) : 32 / PIXW[d];
    wr   = n;
    ov   = 1'b0;
    if (!WRAPP[d] && (b + n > 4096)) begin
      wr = 4096 - b;
      ov = 1'b1;
    end
    for (int unsigned i = 0; i < wr; i++) begin
      e.is_done = 1'b0;
      e.cyc     = cyc + i;
      e.addr    = 12'((b + i) % 4096);
      e.data    = mode ? 4'(dados_in & mask)
                       : 4'((dados_in >> (32 - (i + 1) * PIXW[d])) & mask);
      e.ovf     = 1'b0;
      expq[d].push_back(e);
    end
    e.is_done = 1'b1;
    e.cyc     = cyc + wr;
    e.addr    = '0;
    e.data    = '0;
    e.ovf     = ov;
    expq[d].push_back(e);
    busy_lo[d] = cyc;
    busy_n[d]  = wr;
    free_at[d] = cyc + wr + 2;
  endtask

  // Model step on every edge, reading inputs that the driver changes on negedges.
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      rst_seen = 1'b1;
      rst_cyc  = cyc;
      for (int d = 0; d < 3; d++) begin
        expq[d].delete();
        free_at[d] = cyc + 1;
        busy_lo[d] = cyc;
        busy_n[d]  = 0;
      end
    end else if (start) begin
      for (int d = 0; d < 3; d++)
        if (cyc >= free_at[d]) accept(d);
    end
  end

  // Monitor: pops whenever a DUT shows a write or a done pulse.
  always @(negedge clock) begin
    exp_t e;
    if (rst_seen) begin
      for (int d = 0; d < 3; d++) begin
        if (cyc == rst_cyc) begin
          chk($sformatf("reset_outputs[%0d]", d),
              {14'b0, m_data[d], m_addr[d], m_wren[d], m_busy[d], m_done[d], m_ovf[d]}, 32'h0);
        end else begin
          chk($sformatf("busy[%0d]", d), 32'(m_busy[d]),
              32'((cyc >= busy_lo[d]) && (cyc < busy_lo[d] + busy_n[d])));
          while (expq[d].size() > 0 && expq[d][0].cyc < cyc) begin
            n_chk++;
            $display("FAIL missed_event[%0d]: actual=none required=%s at cycle %0d (now %0d)",
                     d, expq[d][0].is_done ? "done" : "write", expq[d][0].cyc, cyc);
            void'(expq[d].pop_front());
          end
          if (m_wren[d] || m_done[d]) begin
            if (expq[d].size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_event[%0d]: actual wren=%0d done=%0d required=idle (cycle %0d)",
                       d, m_wren[d], m_done[d], cyc);
            end else begin
              e = expq[d].pop_front();
              chk($sformatf("kind_is_done[%0d]", d), 32'(m_done[d]), 32'(e.is_done));
              chk($sformatf("event_cycle[%0d]", d), cyc, e.cyc);
              if (!e.is_done) begin
                chk($sformatf("wraddress[%0d]", d), 32'(m_addr[d]), 32'(e.addr));
                chk($sformatf("data[%0d]", d), 32'(m_data[d]), 32'(e.data));
              end
              chk($sformatf("overflow[%0d]", d), 32'(m_ovf[d]), 32'(e.ovf));
            end
          end
        end
      end
    end
  end

  task automatic scramble();
    dados_in      = $urandom;
    endereco_base = 12'($urandom);
    count         = 13'($urandom);
    mode          = 1'($urandom);
  endtask

  task automatic job(input logic m, input logic [31:0] w, input logic [11:0] b, input logic [12:0] c);
    @(negedge clock);
    mode = m; dados_in = w; endereco_base = b; count = c; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    int unsigned guard = 0;
    while (cyc < free_at[0] || cyc < free_at[1] || cyc < free_at[2]) begin
      @(negedge clock);
      scramble();
      guard++;
      if (guard > 20000) begin
        n_chk++;
        $display("FAIL idle_timeout: actual=busy required=idle after %0d cycles", guard);
        break;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    int unsigned seen;
    // Reset for two edges with start held high: nothing may start.
    reset = 1'b1; start = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);

    job(1'b0, 32'hA500_0001, 12'h010, 13'd0);  wait_idle();
    job(1'b0, 32'h1234_5678, 12'hFFE, 13'd0);  wait_idle();
    job(1'b1, 32'hFFFF_FFFF, 12'hFFC, 13'd10); wait_idle();
    job(1'b1, 32'h0000_0000, 12'h000, 13'd0);  wait_idle();

    // Start pulses while busy and on the 4bpp instance's done cycle; inputs
    // are scrambled every cycle of the job.
    job(1'b0, 32'hC3A5_0F1E, 12'h200, 13'd0);
    repeat (2) @(negedge clock);
    start = 1'b1; @(negedge clock); start = 1'b0;
    repeat (5) @(negedge clock);
    start = 1'b1; @(negedge clock); start = 1'b0;
    wait_idle();

    // Reset on the 5th write of an UNPACK job.
    job(1'b0, 32'h5A5A_F00F, 12'h100, 13'd0);
    seen = (wren_a === 1'b1) ? 1 : 0;
    for (int unsigned k = 0; k < 50 && seen < 5; k++) begin
      @(negedge clock);
      if (wren_a === 1'b1) seen++;
    end
    if (seen < 5) begin
      n_chk++;
      $display("FAIL fifth_write_timeout: actual=%0d writes required=5", seen);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    for (int j = 0; j < 40; j++) begin
      logic [11:0] b;
      b = ($urandom_range(0, 1) == 1) ? 12'(12'hFE0 + $urandom_range(0, 31)) : 12'($urandom);
      job(1'($urandom), $urandom, b, 13'($urandom_range(0, 48)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 10)) @(negedge clock);
        start = 1'b1; @(negedge clock); start = 1'b0;
      end
      wait_idle();
    end

    repeat (3) @(negedge clock);
    for (int d = 0; d < 3; d++)
      chk($sformatf("queue_drained[%0d]", d), 32'(expq[d].size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
